// File: rtl/control_pipeline_pkg.sv
// Control-bundle layout, bubble constant and forward-select codes shared by the decoder and the pipeline.
// Bundle bit 11 is spare and always travels as written.
package control_pipeline_pkg;

   localparam int CTRL_W = 12;
   localparam int REG_W  = 5;

   localparam int B_JUMP       = 0;
   localparam int B_ALU_SRC    = 1;
   localparam int B_REG_WRITE  = 2;
   localparam int B_REG_DST    = 3;
   localparam int B_MEM_TO_REG = 4;
   localparam int B_MEM_WRITE  = 5;
   localparam int B_MEM_READ   = 6;
   localparam int B_ALU_OP_LO  = 7;
   localparam int B_ALU_OP_HI  = 8;
   localparam int B_BRANCH_NE  = 9;
   localparam int B_BRANCH_EQ  = 10;
   localparam int B_SPARE      = 11;

   typedef logic [CTRL_W-1:0] ctrl_t;
   typedef logic [REG_W-1:0]  reg_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_t;

   // EX/MEM result is younger than MEM/WB, so it must win when both match.
   function automatic logic [1:0] fwd_select(input reg_t src,
                                             input logic mem_rw, input reg_t mem_wreg,
                                             input logic wb_rw,  input reg_t wb_wreg);
      if (mem_rw && mem_wreg != '0 && mem_wreg == src)
         return FWD_EXMEM;
      else if (wb_rw && wb_wreg != '0 && wb_wreg == src)
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/control_pipeline_hazard_unit.sv
// Combinational branch, hazard and forwarding decisions for control_pipeline.
// Forwarding and the load-use-only stall exist when CONTROL_PIPELINE_FORWARDING_EN is defined.
module control_pipeline_hazard_unit
   import control_pipeline_pkg::*;
(
   input  logic       active,
   input  logic       id_jump,
   input  reg_t       id_rs,
   input  reg_t       id_rt,
   input  logic       ex_branch_eq,
   input  logic       ex_branch_ne,
   input  logic       ex_mem_read,
   input  logic       ex_reg_write,
   input  reg_t       ex_wreg,
   input  reg_t       ex_rs,
   input  reg_t       ex_rt,
   input  logic       ex_zero,
   input  logic       mem_reg_write,
   input  reg_t       mem_wreg,
   input  logic       wb_reg_write,
   input  reg_t       wb_wreg,
   output logic       stall,
   output logic       flush_ifid,
   output logic       branch_taken,
   output logic       load_bubble,
   output logic [1:0] forward_a,
   output logic [1:0] forward_b
);

   logic       taken_raw;
   logic       hazard_raw;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       unused_inputs;

   assign taken_raw = (ex_branch_eq & ex_zero) | (ex_branch_ne & ~ex_zero);

`ifdef CONTROL_PIPELINE_FORWARDING_EN
   assign hazard_raw = ex_mem_read && (ex_wreg != '0) &&
                       ((ex_wreg == id_rs) || (ex_wreg == id_rt));
   assign fwd_a_sel  = fwd_select(ex_rs, mem_reg_write, mem_wreg, wb_reg_write, wb_wreg);
   assign fwd_b_sel  = fwd_select(ex_rt, mem_reg_write, mem_wreg, wb_reg_write, wb_wreg);
   assign unused_inputs = ex_reg_write;
`else
   logic rs_hit;
   logic rt_hit;

   // Without bypass paths any in-flight writer of a source register must drain to WB first.
   assign rs_hit = (id_rs != '0) && ((ex_reg_write  && ex_wreg  == id_rs) ||
                                     (mem_reg_write && mem_wreg == id_rs));
   assign rt_hit = (id_rt != '0) && ((ex_reg_write  && ex_wreg  == id_rt) ||
                                     (mem_reg_write && mem_wreg == id_rt));
   assign hazard_raw = rs_hit | rt_hit;
   assign fwd_a_sel  = FWD_RF;
   assign fwd_b_sel  = FWD_RF;
   assign unused_inputs = ^{ex_mem_read, ex_rs, ex_rt, wb_reg_write, wb_wreg};
`endif

   assign branch_taken = active & taken_raw;
   assign stall        = active & hazard_raw & ~taken_raw;
   // A stalled jump must stay in IF/ID, so it only flushes once it actually issues.
   assign flush_ifid   = active & (taken_raw | (id_jump & ~hazard_raw));
   assign load_bubble  = taken_raw | hazard_raw;
   assign forward_a    = active ? fwd_a_sel : 2'(FWD_RF);
   assign forward_b    = active ? fwd_b_sel : 2'(FWD_RF);

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers of a 5-stage MIPS-style pipeline.
// Define CONTROL_PIPELINE_FORWARDING_EN to enable operand forwarding (otherwise RAW hazards stall).
module control_pipeline
   import control_pipeline_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              ex_zero,
   output logic              stall,
   output logic              flush_ifid,
   output logic              branch_taken,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CTRL_W-1:0] wb_ctrl,
   output logic [REG_W-1:0]  ex_wreg,
   output logic [REG_W-1:0]  mem_wreg,
   output logic [REG_W-1:0]  wb_wreg,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b
);

   reg_t id_wreg;
   reg_t ex_rs;
   reg_t ex_rt;
   logic load_bubble;

   assign id_wreg = id_ctrl[B_REG_DST] ? id_rd : id_rt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_ctrl  <= CTRL_BUBBLE;
         ex_wreg  <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         mem_ctrl <= CTRL_BUBBLE;
         mem_wreg <= '0;
         wb_ctrl  <= CTRL_BUBBLE;
         wb_wreg  <= '0;
      end else begin
         if (load_bubble) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_wreg <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
         end else begin
            ex_ctrl <= id_ctrl;
            ex_wreg <= id_wreg;
            ex_rs   <= id_rs;
            ex_rt   <= id_rt;
         end
         mem_ctrl <= ex_ctrl;
         mem_wreg <= ex_wreg;
         wb_ctrl  <= mem_ctrl;
         wb_wreg  <= mem_wreg;
      end
   end

   control_pipeline_hazard_unit u_hazard (
      .active        (reset_n),
      .id_jump       (id_ctrl[B_JUMP]),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .ex_branch_eq  (ex_ctrl[B_BRANCH_EQ]),
      .ex_branch_ne  (ex_ctrl[B_BRANCH_NE]),
      .ex_mem_read   (ex_ctrl[B_MEM_READ]),
      .ex_reg_write  (ex_ctrl[B_REG_WRITE]),
      .ex_wreg       (ex_wreg),
      .ex_rs         (ex_rs),
      .ex_rt         (ex_rt),
      .ex_zero       (ex_zero),
      .mem_reg_write (mem_ctrl[B_REG_WRITE]),
      .mem_wreg      (mem_wreg),
      .wb_reg_write  (wb_ctrl[B_REG_WRITE]),
      .wb_wreg       (wb_wreg),
      .stall         (stall),
      .flush_ifid    (flush_ifid),
      .branch_taken  (branch_taken),
      .load_bubble   (load_bubble),
      .forward_a     (forward_a),
      .forward_b     (forward_b)
   );

endmodule

// File: tb/tb_control_pipeline.sv
// Directed checks of control_pipeline: reset, load-use, RAW forwarding, branches, jumps and $0 writes.
// Expectations adapt to CONTROL_PIPELINE_FORWARDING_EN.
module tb_control_pipeline;

   // Hand-encoded bundles (bit 10 beq, 9 bne, 8:7 aluop, 6 mread, 5 mwrite, 4 m2r, 3 regdst, 2 regwr, 1 alusrc, 0 jump)
   localparam logic [11:0] C_NOP  = 12'h000;
   localparam logic [11:0] C_ADD  = 12'h10C;
   localparam logic [11:0] C_LW   = 12'h056;
   localparam logic [11:0] C_BEQ  = 12'h480;
   localparam logic [11:0] C_BNE  = 12'h280;
   localparam logic [11:0] C_ADDI = 12'h006;
   localparam logic [11:0] C_J    = 12'h001;
   localparam logic [11:0] C_BLD  = 12'h4C4;

`ifdef CONTROL_PIPELINE_FORWARDING_EN
   localparam int          LU_STALLS  = 1;
   localparam int          RAW_STALLS = 0;
   localparam logic [1:0]  FWD_LOAD   = 2'b01;
   localparam logic [1:0]  FWD_ALU    = 2'b10;
`else
   localparam int          LU_STALLS  = 2;
   localparam int          RAW_STALLS = 2;
   localparam logic [1:0]  FWD_LOAD   = 2'b00;
   localparam logic [1:0]  FWD_ALU    = 2'b00;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] id_ctrl;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        ex_zero;
   logic        stall, flush_ifid, branch_taken;
   logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
   logic [1:0]  forward_a, forward_b;

   int err_count   = 0;
   int check_count = 0;
   int n_stalls;

   control_pipeline dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .id_ctrl      (id_ctrl),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .ex_zero      (ex_zero),
      .stall        (stall),
      .flush_ifid   (flush_ifid),
      .branch_taken (branch_taken),
      .ex_ctrl      (ex_ctrl),
      .mem_ctrl     (mem_ctrl),
      .wb_ctrl      (wb_ctrl),
      .ex_wreg      (ex_wreg),
      .mem_wreg     (mem_wreg),
      .wb_wreg      (wb_wreg),
      .forward_a    (forward_a),
      .forward_b    (forward_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic set_id(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic z);
      id_ctrl = c;
      id_rs   = rs;
      id_rt   = rt;
      id_rd   = rd;
      ex_zero = z;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      set_id(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   // Holds an instruction in ID until it issues, counting stall cycles (bounded).
   task automatic issue(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, output int stalls);
      stalls = 0;
      set_id(c, rs, rt, rd, 1'b0);
      #1;
      while (stall && stalls < 8) begin
         stalls++;
         tick();
         #1;
      end
      if (stall) check("issue_timeout", 32'd1, 32'd0);
      tick();
   endtask

   initial begin
      // Reset with a jump sitting in ID: nothing may assert
      reset_n = 1'b0;
      set_id(C_J, 5'd1, 5'd2, 5'd3, 1'b0);
      #2;
      check("rst_ex_ctrl",  32'(ex_ctrl), 32'h0);
      check("rst_wb_ctrl",  32'(wb_ctrl), 32'h0);
      check("rst_stall",    32'(stall), 32'd0);
      check("rst_flush",    32'(flush_ifid), 32'd0);
      check("rst_taken",    32'(branch_taken), 32'd0);
      check("rst_fwd_a",    32'(forward_a), 32'd0);
      reset_n = 1'b1;
      #1;
      check("jump_flush",   32'(flush_ifid), 32'd1);
      check("jump_stall",   32'(stall), 32'd0);
      tick();
      check("jump_in_ex",   32'(ex_ctrl), 32'(C_J));

      // lw $2,0($1); add $3,$2,$4
      do_reset();
      issue(C_LW, 5'd1, 5'd2, 5'd0, n_stalls);
      check("lw_wreg",      32'(ex_wreg), 32'd2);
      issue(C_ADD, 5'd2, 5'd4, 5'd3, n_stalls);
      check("lu_stalls",    32'(n_stalls), 32'(LU_STALLS));
      check("lu_ex_ctrl",   32'(ex_ctrl), 32'(C_ADD));
      check("lu_ex_wreg",   32'(ex_wreg), 32'd3);
      check("lu_fwd_a",     32'(forward_a), 32'(FWD_LOAD));
      check("lu_fwd_b",     32'(forward_b), 32'd0);

      // add $2,$1,$1; sub $5,$2,$2
      do_reset();
      issue(C_ADD, 5'd1, 5'd1, 5'd2, n_stalls);
      issue(C_ADD, 5'd2, 5'd2, 5'd5, n_stalls);
      check("raw_stalls",   32'(n_stalls), 32'(RAW_STALLS));
      check("raw_ex_wreg",  32'(ex_wreg), 32'd5);
      check("raw_fwd_a",    32'(forward_a), 32'(FWD_ALU));
      check("raw_fwd_b",    32'(forward_b), 32'(FWD_ALU));

      // beq taken
      do_reset();
      issue(C_BEQ, 5'd1, 5'd2, 5'd0, n_stalls);
      set_id(C_ADD, 5'd3, 5'd4, 5'd6, 1'b1);
      #1;
      check("beq_taken",    32'(branch_taken), 32'd1);
      check("beq_flush",    32'(flush_ifid), 32'd1);
      check("beq_stall",    32'(stall), 32'd0);
      tick();
      check("beq_bubble",   32'(ex_ctrl), 32'h0);
      check("beq_bub_wreg", 32'(ex_wreg), 32'd0);
      check("beq_mem",      32'(mem_ctrl), 32'(C_BEQ));

      // beq not taken, then drain to WB and async reset mid-cycle
      do_reset();
      issue(C_BEQ, 5'd1, 5'd2, 5'd0, n_stalls);
      set_id(C_ADD, 5'd3, 5'd4, 5'd6, 1'b0);
      #1;
      check("bnt_taken",    32'(branch_taken), 32'd0);
      check("bnt_flush",    32'(flush_ifid), 32'd0);
      tick();
      check("bnt_ex_ctrl",  32'(ex_ctrl), 32'(C_ADD));
      check("bnt_ex_wreg",  32'(ex_wreg), 32'd6);
      set_id(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      tick();
      check("move_wb_ctrl", 32'(wb_ctrl), 32'(C_ADD));
      check("move_wb_wreg", 32'(wb_wreg), 32'd6);
      check("move_mem",     32'(mem_ctrl), 32'h0);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_wb_ctrl", 32'(wb_ctrl), 32'h0);
      check("arst_wb_wreg", 32'(wb_wreg), 32'd0);
      reset_n = 1'b1;

      // load-use and taken branch at once: flush wins
      do_reset();
      issue(C_BLD, 5'd1, 5'd2, 5'd0, n_stalls);
      set_id(C_ADD, 5'd2, 5'd4, 5'd6, 1'b1);
      #1;
      check("prio_stall",   32'(stall), 32'd0);
      check("prio_flush",   32'(flush_ifid), 32'd1);
      check("prio_taken",   32'(branch_taken), 32'd1);
      tick();
      check("prio_bubble",  32'(ex_ctrl), 32'h0);

      // bne taken on zero=0
      do_reset();
      issue(C_BNE, 5'd1, 5'd2, 5'd0, n_stalls);
      set_id(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      check("bne_taken",    32'(branch_taken), 32'd1);

      // writes to $0 never create hazards or forwarding
      do_reset();
      issue(C_ADDI, 5'd1, 5'd0, 5'd0, n_stalls);
      check("zero_wreg",    32'(ex_wreg), 32'd0);
      issue(C_ADD, 5'd0, 5'd0, 5'd3, n_stalls);
      check("zero_stalls",  32'(n_stalls), 32'd0);
      check("zero_fwd_a",   32'(forward_a), 32'd0);
      check("zero_fwd_b",   32'(forward_b), 32'd0);
      issue(C_LW, 5'd1, 5'd0, 5'd0, n_stalls);
      issue(C_ADD, 5'd0, 5'd0, 5'd3, n_stalls);
      check("zero_lu",      32'(n_stalls), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
